// File: rtl/board_uart_tx.sv
// board_uart_tx: snapshots the board cells and game status, then sends them as a 12-byte ASCII line over UART 8N1
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : one-cycle request to send the current board
//   raddr_o       : read address to the register array
//   rdata_i       : cell contents, valid one cycle after raddr_o
//   gameover_i    : game status, bits [1:0] used
//   txd_o, busy_o : serial line (idle high) and frame-in-progress flag
module board_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NCELLS = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output logic [3:0] raddr_o,
  input  logic [1:0] rdata_i,
  input  logic [9:0] gameover_i,
  output logic       txd_o,
  output logic       busy_o
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NBYTES = NCELLS + 3;
  localparam int YW = $clog2(NBYTES);
  localparam int CW = $clog2(NCELLS);
  typedef enum logic [1:0] {IDLE, SNAP, SEND} state_e;
  state_e state_q;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d, sc_q, raddr_q;
  logic [YW-1:0] byte_q, byte_d;
  logic [1:0] cells_q [NCELLS];
  logic [1:0] status_q, cell_sel;
  logic [7:0] ch;
  logic baud_end, bit_end, frame_end, pending_q, txd_q, txd_d, busy_q;
  logic unused_go;
  assign unused_go = ^gameover_i[9:2];
  assign raddr_o = raddr_q;
  assign txd_o = txd_q;
  assign busy_o = busy_q;
  always_comb begin
    baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
    bit_end = bit_q == 4'd9;
    frame_end = baud_end && bit_end && byte_q == YW'(NBYTES - 1);
    baud_d = baud_end ? '0 : baud_q + 1'b1;
    bit_d = !baud_end ? bit_q : bit_end ? 4'd0 : bit_q + 4'd1;
    byte_d = !(baud_end && bit_end) ? byte_q : frame_end ? '0 : byte_q + 1'b1;
    cell_sel = cells_q[byte_d < YW'(NCELLS) ? CW'(byte_d) : '0];
    ch = byte_d < YW'(NCELLS) ? (cell_sel == 2'd0 ? 8'h2E : cell_sel == 2'd1 ? 8'h58 :
                                 cell_sel == 2'd2 ? 8'h4F : 8'h3F) :
         byte_d == YW'(NCELLS) ? (status_q == 2'd0 ? 8'h2D : status_q == 2'd1 ? 8'h31 :
                                  status_q == 2'd2 ? 8'h32 : 8'h54) :
         byte_d == YW'(NCELLS + 1) ? 8'h0D : 8'h0A;
    // bit 0 is the start bit, bit 9 the stop bit, bits 1..8 carry data LSB first
    txd_d = bit_d == 4'd0 ? 1'b0 : bit_d == 4'd9 ? 1'b1 : ch[3'(bit_d - 4'd1)];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
      raddr_q <= '0;
      pending_q <= 1'b0;
      sc_q <= '0;
      baud_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      status_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= SNAP;
          status_q <= gameover_i[1:0];
          busy_q <= 1'b1;
          sc_q <= '0;
          raddr_q <= '0;
        end
        SNAP: begin
          // sc_q counts 0..NCELLS; data for address k arrives while sc_q = k+1
          pending_q <= pending_q | start_i;
          sc_q <= sc_q + 4'd1;
          raddr_q <= sc_q < 4'(NCELLS - 1) ? sc_q + 4'd1 : '0;
          if (sc_q != '0) cells_q[CW'(sc_q - 4'd1)] <= rdata_i;
          if (sc_q == 4'(NCELLS)) begin
            state_q <= SEND;
            txd_q <= 1'b0;
            baud_q <= '0;
            bit_q <= '0;
            byte_q <= '0;
          end
        end
        SEND: begin
          baud_q <= baud_d;
          bit_q <= bit_d;
          byte_q <= byte_d;
          txd_q <= frame_end ? 1'b1 : txd_d;
          pending_q <= frame_end ? 1'b0 : pending_q | start_i;
          if (frame_end) begin
            // a request seen during the frame (even on its last cycle) re-snaps with no idle gap
            state_q <= (pending_q | start_i) ? SNAP : IDLE;
            busy_q <= pending_q | start_i;
            status_q <= gameover_i[1:0];
            sc_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_uart_tx.sv
// tb_board_uart_tx: scoreboard bench decoding the UART line against expected board text
module tb_board_uart_tx;
  localparam int CPB = 4;
  localparam int FRAME = 10 + 120 * CPB;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] rdata;
  logic [9:0] gameover = '0;
  logic [3:0] raddr;
  logic txd, busy;
  logic [1:0] mem [16];
  logic [7:0] exp_q [$];
  logic [7:0] mon_b, mon_e;
  logic mon_ok;
  bit mon_en = 1'b1;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdata <= mem[raddr];
  board_uart_tx #(.CLKS_PER_BIT(CPB), .NCELLS(9)) dut (
    .clk(clk), .rst(rst), .start_i(start), .raddr_o(raddr), .rdata_i(rdata),
    .gameover_i(gameover), .txd_o(txd), .busy_o(busy)
  );
  function automatic logic [7:0] cell_ch(input logic [1:0] c);
    case (c)
      2'd0: return 8'h2E;
      2'd1: return 8'h58;
      2'd2: return 8'h4F;
      default: return 8'h3F;
    endcase
  endfunction
  function automatic logic [7:0] stat_ch(input logic [1:0] s);
    case (s)
      2'd0: return 8'h2D;
      2'd1: return 8'h31;
      2'd2: return 8'h32;
      default: return 8'h54;
    endcase
  endfunction
  task automatic push_line();
    for (int i = 0; i < 9; i++) exp_q.push_back(cell_ch(mem[i]));
    exp_q.push_back(stat_ch(gameover[1:0]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask
  task automatic set_board(input logic [17:0] b, input logic [1:0] go);
    for (int i = 0; i < 9; i++) mem[i] = b[2*(8-i) +: 2];
    gameover = {8'hA5, go};
  endtask
  // returns at the negedge of cycle T+1
  task automatic pulse_start();
    @(negedge clk);
    push_line();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (txd === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      mon_ok = txd === 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      mon_ok = mon_ok && txd === 1'b1;
      if (mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL uart_byte: got %h, required no byte", mon_b);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_b !== mon_e || !mon_ok) begin
            errors++;
            $display("FAIL uart_byte: got %h framing_ok=%b, required %h framing_ok=1", mon_b, mon_ok, mon_e);
          end
        end
      end
    end
  end
  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes never received, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({txd, busy, raddr} !== {1'b1, 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL reset_idle: txd=%b busy=%b raddr=%0d, required 1 0 0", txd, busy, raddr);
      end
    end
  endtask
  task automatic test_basic();
    int c0;
    set_board({2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10}, 2'b00);
    pulse_start();
    c0 = cyc;
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (raddr !== 4'(k) || busy !== 1'b1) begin
        errors++;
        $display("FAIL snap_raddr: raddr=%0d busy=%b, required %0d 1", raddr, busy, k);
      end
      @(negedge clk);
    end
    checks++;
    if ({raddr, txd, busy} !== {4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL snap_end: raddr=%0d txd=%b busy=%b, required 0 1 1", raddr, txd, busy);
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin
      errors++;
      $display("FAIL first_start_bit: txd=%b, required 0", txd);
    end
    wait_idle();
    checks++;
    if (cyc - c0 != FRAME) begin
      errors++;
      $display("FAIL busy_len: %0d cycles, required %0d", cyc - c0, FRAME);
    end
    check_drained("basic_line");
  endtask
  task automatic test_wave();
    logic [7:0] b = 8'h3F;
    logic e;
    set_board('1, 2'b11);
    pulse_start();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      e = (i / CPB == 0) ? 1'b0 : (i / CPB == 9) ? 1'b1 : b[i / CPB - 1];
      checks++;
      if (txd !== e) begin
        errors++;
        $display("FAIL wave_bit: cycle %0d txd=%b, required %b", i, txd, e);
      end
      @(negedge clk);
    end
    wait_idle();
    check_drained("wave_line");
  endtask
  task automatic test_back_to_back();
    int c0;
    logic bad = 1'b0;
    set_board({2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01}, 2'b01);
    pulse_start();
    c0 = cyc;
    repeat (40) @(negedge clk);
    push_line();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
    end
    wait_idle();
    checks++;
    if (cyc - c0 != 2 * FRAME) begin
      errors++;
      $display("FAIL b2b_busy_len: %0d cycles, required %0d", cyc - c0, 2 * FRAME);
    end
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_idle_after: activity seen, required idle");
    end
    check_drained("b2b_lines");
  endtask
  task automatic test_change_mid();
    set_board({2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00}, 2'b00);
    pulse_start();
    repeat (135) @(negedge clk);
    set_board({2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10}, 2'b10);
    wait_idle();
    check_drained("change_old_line");
    pulse_start();
    wait_idle();
    check_drained("change_new_line");
  endtask
  task automatic test_reset_mid();
    logic bad = 1'b0;
    set_board({2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11}, 2'b01);
    pulse_start();
    repeat (215) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({txd, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_abort: txd=%b busy=%b, required 1 0", txd, busy);
    end
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_quiet: activity after reset, required idle");
    end
    mon_en = 1'b1;
    pulse_start();
    wait_idle();
    check_drained("reset_new_line");
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    test_reset();
    test_basic();
    test_wave();
    test_back_to_back();
    test_change_mid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/board_uart_tx.md
Name: board_uart_tx

Overview:
- Reader-side counterpart to the button FSM that writes the board register array.
- On request, snapshots the 9 board cells through a spare read port of the register array, plus the gameover status.
- Serialises the snapshot as a 12-byte ASCII line over UART 8N1 (idle high), for remote viewing or logging over the USB-UART bridge.
- Sits beside the vga block; shares the read-address/read-data style of interface.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..4095
- NCELLS, 9, board cells snapshotted, addresses 0..NCELLS-1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to send the current board (typically tied to wen)
- raddr  out  4  read address to the register array
- rdata  in  2  cell contents; valid one cycle after raddr (registered read)
- gameover  in  10  game status; only bits [1:0] are used
- txd  out  1  UART serial output
- busy  out  1  high from the cycle after an accepted start until the frame completes

Behaviour:
- Reset values: txd=1, busy=0, raddr=0, pending=0, state=IDLE. Reset anywhere mid-frame aborts the frame; txd is 1 on the next cycle, with no partial byte completion.
- States: IDLE -> SNAP -> SEND -> IDLE.
- IDLE:
  - start=1 in cycle T: latch gameover[1:0] into a status register and enter SNAP.
  - busy=1 from T+1.
- SNAP:
  - raddr = 0,1,...,8 on cycles T+1..T+9.
  - rdata is captured into buffer[k] on the cycle after raddr=k (T+2..T+10).
  - The capture at T+10 moves the block to SEND.
  - raddr returns to 0 after the last address; addresses 9..15 are never driven.
- Byte sequence (12 bytes):
  - Bytes 0..8 are cells 0..8 in order, mapped 00->'.'(0x2E), 01->'X'(0x58), 10->'O'(0x4F), 11->'?'(0x3F).
  - Byte 9 is status, mapped 00->'-'(0x2D), 01->'1'(0x31), 10->'2'(0x32), 11->'T'(0x54).
  - Byte 10 is CR (0x0D); byte 11 is LF (0x0A).
- Character framing:
  - Each character: start bit (0), data bits LSB first, stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - The next start bit follows the stop bit with no idle gap.
- SEND timing:
  - txd falls at the first cycle of SEND (T+11).
  - The frame lasts exactly 120*CLKS_PER_BIT cycles.
  - After the last stop bit: return to IDLE and deassert busy. If pending=1, instead clear pending and enter SNAP directly; busy stays 1 and txd stays 1 for the SNAP cycles.
- start while busy: sets pending. Multiple starts collapse into one pending request. start in the final SEND cycle also sets pending.
- The snapshot is taken once per frame. Board writes during SEND do not alter the bytes in flight; gameover changes after T are ignored for this frame.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT).
  - Bit index is 0..9 within a character.
  - Byte index is 0..11.
  - All counters wrap to 0 only on their terminal count; there is no free-running baud tick, and bit timing restarts from each frame start.

Test Plan:
- Reset, then idle 50 cycles -> txd=1, busy=0, raddr=0 throughout.
- CLKS_PER_BIT=4; board {01,00,10,00,01,00,00,00,10}, gameover=0; pulse start -> raddr 0..8 on T+1..T+9; decoded line "X.O.X...O-\r\n"; busy high exactly 10+480 cycles; txd low at T+11.
- Board all 11, gameover[1:0]=11 -> line "?????????T\r\n"; check bit-exact waveform of the first byte (0x3F, LSB first) at 4 cycles/bit.
- Three start pulses during SEND of frame 1 -> exactly one additional frame follows with no idle between the stop bit and SNAP; busy stays high; then IDLE.
- Change register contents and gameover to 10 at byte 3 of a frame -> current line unchanged; a subsequent start reflects new values with status '2'.
- Assert rst for one cycle mid-byte 5 -> txd=1, busy=0 next cycle; no further edges until a new start; the next frame is correct from byte 0.
